// File: rtl/fetch_pkg.sv
// Shared types and helpers for the 3BC fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFF_W = 6;
  localparam int unsigned CNT_W = 16;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [OFF_W-1:0] off_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  // Relative branch: sign-extend the offset; the sum wraps modulo 2**PC_W.
  function automatic pc_t branch_target(input pc_t pc, input off_t off);
    pc_t ext;
    ext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    return pc + ext;
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating event counter with synchronous reset/clear and count enable.
module sat_counter
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output cnt_t count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencing for the 3BC core: Start/Done handshake,
// halt/jump/branch/stall handling, retire/cycle counters and runaway timeout.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter pc_t  PROG0_BASE = 10'd0,
  parameter pc_t  PROG1_BASE = 10'd256,
  parameter pc_t  PROG2_BASE = 10'd512,
  parameter pc_t  PROG3_BASE = 10'd768,
  parameter cnt_t MAX_CYCLES = 16'd50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        Jump,
  input  logic [9:0]  JumpTarget,
  input  logic        Branch,
  input  logic [5:0]  BranchOffset,
  output logic [9:0]  InstAddress,
  output logic        InstValid,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic [15:0] InstCount,
  output logic [15:0] CycleCount
);

  state_t state, state_nx;
  pc_t    pc, pc_nx;
  pc_t    base;
  logic   timeout_q, timeout_nx;
  logic   inst_en, cyc_en, cnt_clr;
  logic   limit_hit;

  always_comb begin
    case (ProgSel)
      2'd0:    base = PROG0_BASE;
      2'd1:    base = PROG1_BASE;
      2'd2:    base = PROG2_BASE;
      default: base = PROG3_BASE;
    endcase
  end

  assign limit_hit = (CycleCount == (MAX_CYCLES - cnt_t'(1)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pc        <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    timeout_nx = timeout_q;
    inst_en    = 1'b0;
    cyc_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nx   = RUN;
          pc_nx      = base;
          timeout_nx = 1'b0;
          cnt_clr    = 1'b1;
        end
      end
      RUN: begin
        cyc_en = 1'b1;
        // The cycle limit pre-empts retirement and every redirect request.
        if (limit_hit) begin
          state_nx   = HALT;
          timeout_nx = 1'b1;
        end else if (!Stall) begin
          inst_en = 1'b1;
          if (Halt) begin
            state_nx = HALT;
          end else if (Jump) begin
            pc_nx = JumpTarget;
          end else if (Branch) begin
            pc_nx = branch_target(pc, BranchOffset);
          end else begin
            pc_nx = pc + pc_t'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  sat_counter u_inst_count (
    .clk    (Clk),
    .reset  (Reset),
    .clear  (cnt_clr),
    .enable (inst_en),
    .count  (InstCount)
  );

  sat_counter u_cycle_count (
    .clk    (Clk),
    .reset  (Reset),
    .clear  (cnt_clr),
    .enable (cyc_en),
    .count  (CycleCount)
  );

  assign InstAddress = pc;
  assign InstValid   = (state == RUN) && !Stall;
  assign Busy        = (state == RUN);
  assign Done        = (state == HALT);
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a shortened cycle limit.
module tb_fetch_sequencer;

  localparam logic [15:0] MAXC = 16'd20;
  localparam int F_ADDR = 0, F_BUSY = 1, F_DONE = 2, F_TO = 3, F_IC = 4, F_CC = 5;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, Jump, Branch;
  logic [1:0]  ProgSel;
  logic [9:0]  JumpTarget;
  logic [5:0]  BranchOffset;
  logic [9:0]  InstAddress;
  logic        InstValid, Busy, Done, Timeout;
  logic [15:0] InstCount, CycleCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          fld;
    logic [15:0] val;
  } exp_t;
  exp_t sbq[$];

  int          m_state;
  logic [9:0]  m_pc;
  logic [15:0] m_ic, m_cc;
  logic        m_to;

  fetch_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .ProgSel      (ProgSel),
    .Stall        (Stall),
    .Halt         (Halt),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Branch       (Branch),
    .BranchOffset (BranchOffset),
    .InstAddress  (InstAddress),
    .InstValid    (InstValid),
    .Busy         (Busy),
    .Done         (Done),
    .Timeout      (Timeout),
    .InstCount    (InstCount),
    .CycleCount   (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int fld);
    case (fld)
      F_ADDR:  obs = {6'd0, InstAddress};
      F_BUSY:  obs = {15'd0, Busy};
      F_DONE:  obs = {15'd0, Done};
      F_TO:    obs = {15'd0, Timeout};
      F_IC:    obs = InstCount;
      F_CC:    obs = CycleCount;
      default: obs = '0;
    endcase
  endfunction

  task automatic expect_after(input string tag, input int fld, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sbq.push_back(e);
  endtask

  function automatic logic [9:0] base_of(input logic [1:0] s);
    case (s)
      2'd0:    base_of = 10'd0;
      2'd1:    base_of = 10'd256;
      2'd2:    base_of = 10'd512;
      default: base_of = 10'd768;
    endcase
  endfunction

  // Reference behaviour for one clock edge given the currently driven inputs.
  task automatic model_step();
    logic [9:0] off_ext;
    if (Reset) begin
      m_state = 0; m_pc = '0; m_ic = '0; m_cc = '0; m_to = 1'b0;
    end else if (m_state != 1) begin
      if (Start) begin
        m_state = 1; m_pc = base_of(ProgSel); m_ic = '0; m_cc = '0; m_to = 1'b0;
      end
    end else begin
      if (m_cc == MAXC - 16'd1) begin
        m_state = 2;
        m_to = 1'b1;
      end else if (!Stall) begin
        if (m_ic != 16'hFFFF) m_ic = m_ic + 16'd1;
        if (Halt) m_state = 2;
        else if (Jump) m_pc = JumpTarget;
        else if (Branch) begin
          off_ext = {{4{BranchOffset[5]}}, BranchOffset};
          m_pc = m_pc + off_ext;
        end else m_pc = m_pc + 10'd1;
      end
      if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    #1;
    check({tag, ":valid"}, {15'd0, InstValid}, {15'd0, (m_state == 1) && !Stall});
    model_step();
    expect_after({tag, ":addr"}, F_ADDR, {6'd0, m_pc});
    expect_after({tag, ":busy"}, F_BUSY, {15'd0, m_state == 1});
    expect_after({tag, ":done"}, F_DONE, {15'd0, m_state == 2});
    expect_after({tag, ":to"},   F_TO,   {15'd0, m_to});
    expect_after({tag, ":ic"},   F_IC,   m_ic);
    expect_after({tag, ":cc"},   F_CC,   m_cc);
    @(posedge Clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, obs(e.fld), e.val);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Stall = 1'b0; Halt = 1'b0;
    Jump = 1'b0; JumpTarget = '0; Branch = 1'b0; BranchOffset = '0;
    @(posedge Clk);
    #1;
    m_state = 0; m_pc = '0; m_ic = '0; m_cc = '0; m_to = 1'b0;
    tick("rst_hold");
    Reset = 1'b0;
    tick("idle");

    // Reset while running at PC=37
    Start = 1'b1; ProgSel = 2'd0; tick("start0");
    Start = 1'b0; Jump = 1'b1; JumpTarget = 10'd35; tick("jmp35");
    Jump = 1'b0; tick("inc36"); tick("inc37");
    Reset = 1'b1;
    expect_after("midrst_addr", F_ADDR, 16'd0);
    expect_after("midrst_busy", F_BUSY, 16'd0);
    expect_after("midrst_done", F_DONE, 16'd0);
    expect_after("midrst_ic",   F_IC,   16'd0);
    tick("midrst");
    Reset = 1'b0;

    // Sequential fetch from program 1
    Start = 1'b1; ProgSel = 2'd1;
    expect_after("p1_base", F_ADDR, 16'd256);
    tick("start1");
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      expect_after("seq_addr", F_ADDR, 16'(256 + i));
      if (i == 5) expect_after("seq_ic5", F_IC, 16'd5);
      tick("seq");
    end

    // Branch, jump priority, wrap-around
    Jump = 1'b1; JumpTarget = 10'd300; tick("jmp300");
    Jump = 1'b0; Branch = 1'b1; BranchOffset = 6'b111011;
    expect_after("br_m5", F_ADDR, 16'd295);
    tick("br");
    Jump = 1'b1; JumpTarget = 10'd10;
    expect_after("jmp_wins", F_ADDR, 16'd10);
    tick("jmpbr");
    Branch = 1'b0; JumpTarget = 10'd1023; tick("jmp1023");
    Jump = 1'b0;
    expect_after("wrap_inc", F_ADDR, 16'd0);
    tick("wrap");
    Jump = 1'b1; JumpTarget = 10'd2; tick("jmp2");
    Jump = 1'b0; Branch = 1'b1; BranchOffset = 6'b111011;
    expect_after("wrap_br", F_ADDR, 16'd1021);
    tick("brwrap");
    Branch = 1'b0; BranchOffset = 6'd31; Branch = 1'b1;
    expect_after("br_p31", F_ADDR, 16'd28);
    tick("brp31");
    Branch = 1'b0; Halt = 1'b1;
    expect_after("halt_done", F_DONE, 16'd1);
    tick("halt1");
    Halt = 1'b0; tick("halted");

    // Stall holds PC and suppresses halt
    Start = 1'b1; ProgSel = 2'd0; tick("start_st");
    Start = 1'b0; Jump = 1'b1; JumpTarget = 10'd40; tick("jmp40");
    Jump = 1'b0; Stall = 1'b1; Halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_after("stall_addr", F_ADDR, 16'd40);
      expect_after("stall_done", F_DONE, 16'd0);
      if (i == 2) begin
        expect_after("stall_cc", F_CC, 16'd4);
        expect_after("stall_ic", F_IC, 16'd1);
      end
      tick("stall");
    end
    Stall = 1'b0;
    expect_after("rel_done", F_DONE, 16'd1);
    expect_after("rel_addr", F_ADDR, 16'd40);
    tick("release");
    Halt = 1'b0;

    // Restart from HALT, then loop into the cycle limit
    Start = 1'b1; ProgSel = 2'd2;
    expect_after("rs_busy", F_BUSY, 16'd1);
    expect_after("rs_addr", F_ADDR, 16'd512);
    expect_after("rs_ic",   F_IC,   16'd0);
    expect_after("rs_cc",   F_CC,   16'd0);
    expect_after("rs_to",   F_TO,   16'd0);
    tick("restart2");
    Start = 1'b0; Jump = 1'b1; JumpTarget = 10'd512;
    for (int i = 1; i <= 20; i++) begin
      if (i == 19) expect_after("to_not_yet", F_DONE, 16'd0);
      if (i == 20) begin
        expect_after("to_done", F_DONE, 16'd1);
        expect_after("to_flag", F_TO,   16'd1);
        expect_after("to_ic",   F_IC,   16'd19);
        expect_after("to_cc",   F_CC,   16'd20);
      end
      tick("loop");
    end
    Jump = 1'b0; tick("to_hold");

    // Restart clears Timeout; Start during RUN is ignored
    Start = 1'b1; ProgSel = 2'd3;
    expect_after("p3_base", F_ADDR, 16'd768);
    expect_after("to_clr",  F_TO,   16'd0);
    tick("start3");
    expect_after("no_restart", F_ADDR, 16'd769);
    tick("start_in_run");
    Start = 1'b0; tick("run_on");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
